// File: rtl/program_sequencer.sv
// program_sequencer: run control and program counter for the single-cycle core.
// It owns the PC and the Start/Done handshake with the harness.
// It stalls the core across multi-cycle data-memory accesses.
// Exec_En is the commit strobe that gates register-file and memory writes.
// Optional feature: define SEQ_CYCLE_COUNT_EN to enable the saturating Cycle_Count.
module program_sequencer #(
    parameter int PC_W = 10
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic            Branch,
    input  logic            Branch_Cond,
    input  logic            Flag,
    input  logic [PC_W-1:0] Target,
    input  logic            Halt,
    input  logic            Mem_Access,
    input  logic            Mem_Ack,
    output logic [PC_W-1:0] PC,
    output logic            Exec_En,
    output logic            Mem_Req,
    output logic            Done,
    output logic [15:0]     Cycle_Count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            launch;

    // Next-state, next-PC and the combinational strobes.
    // Halt outranks Mem_Access, and Mem_Access outranks Branch.
    // An illegal Branch+Mem_Access decode is therefore handled as a memory access.
    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        Exec_En   = 1'b0;
        Mem_Req   = 1'b0;
        launch    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                if (Halt) begin
                    Exec_En   = 1'b1;
                    state_nxt = DONE;
                end else if (Mem_Access) begin
                    state_nxt = MEM_WAIT;
                end else if (Branch && (!Branch_Cond || Flag)) begin
                    Exec_En = 1'b1;
                    pc_nxt  = Target;
                end else begin
                    Exec_En = 1'b1;
                    pc_nxt  = PC + PC_ONE;
                end
            end
            MEM_WAIT: begin
                Mem_Req = 1'b1;
                if (Mem_Ack) begin
                    Exec_En   = 1'b1;
                    pc_nxt    = PC + PC_ONE;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, PC and the registered Done flag.
    // Done follows entry into DONE and clears on the relaunch edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            PC    <= '0;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
            Done  <= (state_nxt == DONE);
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;

    // Count cycles spent in RUN or MEM_WAIT, saturating at all-ones.
    // The count clears on launch and holds in DONE so the harness can read it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cycle_cnt <= 16'h0000;
        end else if (launch) begin
            cycle_cnt <= 16'h0000;
        end else if ((state == RUN || state == MEM_WAIT) && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign Cycle_Count = cycle_cnt;
`else
    assign Cycle_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and randomized checks of program_sequencer.
// The reference model below is a behavioural model of the sequencer.
// The model is built for the default build and also for a build with SEQ_CYCLE_COUNT_EN defined.
module tb_program_sequencer;

    localparam int PW = 10;
    localparam int PC_MOD = 1 << PW;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start, Branch, Branch_Cond, Flag, Halt, Mem_Access, Mem_Ack;
    logic [PW-1:0] Target;
    logic [PW-1:0] PC;
    logic          Exec_En, Mem_Req, Done;
    logic [15:0]   Cycle_Count;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: mode 0=idle, 1=running, 2=waiting on memory, 3=finished.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    program_sequencer #(.PC_W(PW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Branch(Branch),
        .Branch_Cond(Branch_Cond), .Flag(Flag), .Target(Target), .Halt(Halt),
        .Mem_Access(Mem_Access), .Mem_Ack(Mem_Ack), .PC(PC), .Exec_En(Exec_En),
        .Mem_Req(Mem_Req), .Done(Done), .Cycle_Count(Cycle_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        Start = 0; Branch = 0; Branch_Cond = 0; Flag = 0; Halt = 0;
        Mem_Access = 0; Mem_Ack = 0; Target = '0;
    endtask

    // Compare DUT against the model at the falling edge.
    // Then advance the model to its state after the next rising edge.
    // Inputs are changed 2 time units after each rising edge.
    task automatic tick();
        int exp_exec, exp_req, exp_cnt;
        @(negedge Clk);
        exp_exec = ((m_mode == 1) && (Halt || !Mem_Access)) || ((m_mode == 2) && Mem_Ack);
        exp_req  = (m_mode == 2);
`ifdef SEQ_CYCLE_COUNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("pc", int'(PC), m_pc);
        chk("exec_en", int'(Exec_En), exp_exec);
        chk("mem_req", int'(Mem_Req), exp_req);
        chk("done", int'(Done), int'(m_mode == 3));
        chk("cycle_count", int'(Cycle_Count), exp_cnt);
        case (m_mode)
            0, 3: if (Start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
            1: begin
                if (m_cnt < 65535) m_cnt++;
                if (Halt) m_mode = 3;
                else if (Mem_Access) m_mode = 2;
                else if (Branch && (!Branch_Cond || Flag)) m_pc = int'(Target);
                else m_pc = (m_pc + 1) % PC_MOD;
            end
            2: begin
                if (m_cnt < 65535) m_cnt++;
                if (Mem_Ack) begin m_mode = 1; m_pc = (m_pc + 1) % PC_MOD; end
            end
            default: m_mode = 0;
        endcase
        @(posedge Clk);
        #2;
    endtask

    initial begin
        int run_cycles;
        Reset_n = 0;
        clear_inputs();
        @(posedge Clk);
        #2;
        tick();
        chk("reset_pc_lit", int'(PC), 0);
        chk("reset_done_lit", int'(Done), 0);
        Reset_n = 1;
        tick();

        // Launch, then run straight-line code.
        Start = 1;
        tick();
        Start = 0;
        for (int i = 0; i < 5; i++) begin
            chk("seq_pc_lit", int'(PC), i);
            chk("seq_exec_lit", int'(Exec_En), 1);
            tick();
        end
        chk("seq_pc5_lit", int'(PC), 5);

        // Conditional branch not taken, then taken, then an unconditional branch.
        Branch = 1; Branch_Cond = 1; Flag = 0; Target = 20;
        tick();
        chk("btru_nt_lit", int'(PC), 6);
        Flag = 1;
        tick();
        chk("btru_t_lit", int'(PC), 20);
        Branch_Cond = 0; Flag = 0; Target = 7;
        tick();
        chk("b_lit", int'(PC), 7);
        clear_inputs();

        // Memory access acknowledged on the third waiting cycle.
        Mem_Access = 1;
        tick();
        Mem_Access = 0;
        for (int i = 0; i < 3; i++) begin
            Mem_Ack = (i == 2);
            #1;
            chk("wait_req_lit", int'(Mem_Req), 1);
            chk("wait_exec_lit", int'(Exec_En), int'(i == 2));
            chk("wait_pc_lit", int'(PC), 7);
            tick();
        end
        Mem_Ack = 0;
        chk("after_ack_pc_lit", int'(PC), 8);

        // Illegal Branch+Mem_Access decode: the access is taken and the target is dropped.
        Branch = 1; Mem_Access = 1; Target = 100;
        tick();
        clear_inputs();
        chk("illegal_req_lit", int'(Mem_Req), 1);
        chk("illegal_pc_lit", int'(PC), 8);
        Mem_Ack = 1;
        tick();
        Mem_Ack = 0;
        chk("illegal_ack_pc_lit", int'(PC), 9);

        // Start in RUN is ignored, then the PC wraps at the top of memory.
        Start = 1;
        tick();
        Start = 0;
        chk("start_ignored_lit", int'(PC), 10);
        Branch = 1; Target = PW'(PC_MOD - 2);
        tick();
        clear_inputs();
        tick();
        chk("wrap_top_lit", int'(PC), PC_MOD - 1);
        tick();
        chk("wrap_zero_lit", int'(PC), 0);
        Branch = 1; Target = 9;
        tick();
        clear_inputs();

        // Halt at PC 9, then hold in DONE.
        Halt = 1;
        tick();
        Halt = 0;
        run_cycles = m_cnt;
        for (int i = 0; i < 3; i++) begin
            chk("done_lit", int'(Done), 1);
            chk("done_pc_lit", int'(PC), 9);
            chk("done_exec_lit", int'(Exec_En), 0);
            tick();
        end
`ifdef SEQ_CYCLE_COUNT_EN
        chk("count_lit", int'(Cycle_Count), 20);
`endif
        chk("model_count_lit", run_cycles, 20);

        // Relaunch from DONE.
        Start = 1;
        tick();
        Start = 0;
        chk("relaunch_pc_lit", int'(PC), 0);
        chk("relaunch_done_lit", int'(Done), 0);

        // Randomized decode inputs.
        for (int i = 0; i < 3000; i++) begin
            Start       = ($urandom_range(7) == 0);
            Halt        = ($urandom_range(39) == 0);
            Mem_Access  = ($urandom_range(5) == 0);
            Mem_Ack     = ($urandom_range(2) == 0);
            Branch      = ($urandom_range(3) == 0);
            Branch_Cond = $urandom_range(1) == 1;
            Flag        = $urandom_range(1) == 1;
            Target      = PW'($urandom_range(PC_MOD - 1));
            tick();
        end
        clear_inputs();

        // Asynchronous reset in the middle of a memory wait.
        Start = 1;
        tick();
        Start = 0;
        tick();
        Mem_Access = 1;
        tick();
        Mem_Access = 0;
        tick();
        Mem_Ack = 1;
        #1;
        chk("pre_reset_req_lit", int'(Mem_Req), 1);
        chk("pre_reset_exec_lit", int'(Exec_En), 1);
        Reset_n = 0;
        #1;
        chk("async_req_lit", int'(Mem_Req), 0);
        chk("async_exec_lit", int'(Exec_En), 0);
        chk("async_pc_lit", int'(PC), 0);
        chk("async_done_lit", int'(Done), 0);
        chk("async_count_lit", int'(Cycle_Count), 0);
        Mem_Ack = 0;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        tick();
        Reset_n = 1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
